mp_deserializer: RTL

MP_DESERIALIZER -- requirements
Module: mp_deserializer

---
 rtl/mp_serdes_pkg.sv | 11 +
 rtl/mp_deserializer_out_reg.sv | 35 +++
 rtl/mp_deserializer.sv | 90 +++++++++
 3 files changed

// File: rtl/mp_serdes_pkg.sv
// Types and constants shared by the serializer and deserializer sides of the link.
package mp_serdes_pkg;

  localparam int unsigned default_width_c = 256;

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } serdes_state_e;

endpackage

// File: rtl/mp_deserializer_out_reg.sv
// Output holding register: presents completed words with valid/ready and flags dropped words.
module mp_deserializer_out_reg
  import mp_serdes_pkg::*;
#(
  parameter int unsigned width_p = default_width_c
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               word_v_i,
  input  logic [width_p-1:0] word_i,
  input  logic               ready_i,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  output logic               ovf_o
);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_o <= '0;
      v_o    <= 1'b0;
      ovf_o  <= 1'b0;
    end else if (word_v_i) begin
      // A held, unaccepted word wins; the newcomer is dropped.
      if (!v_o || ready_i) begin
        data_o <= word_i;
        v_o    <= 1'b1;
      end else begin
        ovf_o <= 1'b1;
      end
    end else if (v_o && ready_i) begin
      v_o <= 1'b0;
    end
  end

endmodule

// File: rtl/mp_deserializer.sv
// Serial-to-parallel deserializer: sof-framed bit capture feeding a valid/ready output register.
module mp_deserializer
  import mp_serdes_pkg::*;
#(
  parameter int unsigned width_p     = default_width_c,
  parameter bit          msb_first_p = 1'b0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               data_i,
  input  logic               v_i,
  input  logic               sof_i,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               ready_i,
  output logic               frame_err_o,
  output logic               ovf_o
);

  localparam int unsigned cnt_w = $clog2(width_p);
  localparam logic [cnt_w-1:0] last_c = cnt_w'(width_p - 1);
  localparam logic [cnt_w-1:0] first_idx_c = msb_first_p ? last_c : '0;

  serdes_state_e      state;
  logic [cnt_w-1:0]   count;
  logic [width_p-1:0] sreg;
  logic [width_p-1:0] word;
  logic [cnt_w-1:0]   bit_idx;
  logic               done;

  // Bits are written in place rather than shifted, so the completed word
  // (including the final bit) is available combinationally in the same cycle.
  always_comb begin
    bit_idx = msb_first_p ? (last_c - count) : count;
    word    = sreg;
    word[bit_idx] = data_i;
    done    = (state == SHIFT) && v_i && !sof_i && (count == last_c);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= HUNT;
      count       <= '0;
      sreg        <= '0;
      frame_err_o <= 1'b0;
    end else if (v_i) begin
      case (state)
        HUNT: begin
          if (sof_i) begin
            sreg[first_idx_c] <= data_i;
            count             <= cnt_w'(1);
            state             <= SHIFT;
          end
        end
        SHIFT: begin
          if (sof_i) begin
            sreg[first_idx_c] <= data_i;
            count             <= cnt_w'(1);
            frame_err_o       <= 1'b1;
          end else if (count == last_c) begin
            sreg  <= word;
            count <= '0;
            state <= HUNT;
          end else begin
            sreg  <= word;
            count <= count + cnt_w'(1);
          end
        end
        default: begin
          state <= HUNT;
          count <= '0;
        end
      endcase
    end
  end

  mp_deserializer_out_reg #(
    .width_p(width_p)
  ) u_out_reg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .word_v_i(done),
    .word_i  (word),
    .ready_i (ready_i),
    .data_o  (data_o),
    .v_o     (v_o),
    .ovf_o   (ovf_o)
  );

endmodule
